asm: RTL and testbench

Serial CRC generator built as an algorithmic state machine. On a start request it latches a 14-bit message and a 4-bit generator polynomial. It performs modulo-2 long division of the message, padded with three zero bits, one bit per clock. It then presents the 3-bit remainder on `CRC`. The block is a standalone datapath-plus-controller used wherever a frame check value must be generated for a fixed-length word.

---
 rtl/asm_pkg.sv | 22 ++
 rtl/crc_step.sv | 25 ++
 rtl/asm.sv | 111 +++++++++++
 tb/tb_asm.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/asm_pkg.sv
// Shared types and default sizing for the serial CRC generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package asm_pkg;

    // Default message and remainder widths; divisor is CRC_W_DEF+1 bits.
    localparam int DATA_W_DEF = 14;
    localparam int CRC_W_DEF  = 3;

    // One division step per message bit plus one per padding zero.
    localparam int STEPS = DATA_W_DEF + CRC_W_DEF;

    // Counter must be able to represent 0..STEPS.
    localparam int CNT_W = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : asm_pkg

// File: rtl/crc_step.sv
// One modulo-2 long-division step: shift one bit into the remainder and
// conditionally subtract (XOR) the generator. Purely combinational, no backpressure.
// Ports: rem_i current remainder, bit_i incoming bit, poly_i generator low
//        bits (x^CRC_W term implied), rem_o next remainder.
module crc_step
    import asm_pkg::*;
#(
    parameter int CRC_W = CRC_W_DEF
) (
    input  logic [CRC_W-1:0] rem_i,
    input  logic             bit_i,
    input  logic [CRC_W-1:0] poly_i,
    output logic [CRC_W-1:0] rem_o
);

    always_comb begin
        rem_o = {rem_i[CRC_W-2:0], bit_i};
        // The bit falling out of the top is the implied x^CRC_W coefficient;
        // when set, the generator divides into the current window.
        if (rem_i[CRC_W-1]) begin
            rem_o = rem_o ^ poly_i;
        end
    end

endmodule : crc_step

// File: rtl/asm.sv
// Serial CRC generator: latches message and generator on E in IDLE, divides
// one bit per clock, 17 cycles from the start edge to a new CRC (default sizes).
// No backpressure: E held high after completion is ignored until it drops.
// Ports: clk, Reset (sync, active-low), E start request, Data message (MSB
//        first), Divisor generator (MSB implied 1), CRC registered remainder.
module asm
    import asm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CRC_W  = CRC_W_DEF
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              E,
    input  logic [DATA_W-1:0] Data,
    input  logic [CRC_W:0]    Divisor,
    output logic [CRC_W-1:0]  CRC
);

    localparam int N_STEPS  = DATA_W + CRC_W;
    localparam int CNT_BITS = $clog2(N_STEPS + 1);
    localparam logic [CNT_BITS-1:0] LAST_STEP = CNT_BITS'(N_STEPS - 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   msg_q,   msg_d;
    logic [CRC_W-1:0]    poly_q,  poly_d;
    logic [CRC_W-1:0]    rem_q,   rem_d;
    logic [CNT_BITS-1:0] cnt_q,   cnt_d;
    logic [CRC_W-1:0]    crc_q,   crc_d;

    logic [CRC_W-1:0]    step_rem;

    // The generator's leading term is always 1, so the supplied MSB is not used.
    logic unused_div_msb;
    assign unused_div_msb = Divisor[CRC_W];

    // The message register shifts left filling with zeros, so once the data
    // bits are exhausted its MSB naturally supplies the padding zeros.
    crc_step #(
        .CRC_W (CRC_W)
    ) u_step (
        .rem_i  (rem_q),
        .bit_i  (msg_q[DATA_W-1]),
        .poly_i (poly_q),
        .rem_o  (step_rem)
    );

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        poly_d  = poly_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;

        case (state_q)
            IDLE: begin
                if (E) begin
                    msg_d   = Data;
                    poly_d  = Divisor[CRC_W-1:0];
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                rem_d = step_rem;
                msg_d = {msg_q[DATA_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_BITS'(1);
                if (cnt_q == LAST_STEP) begin
                    // Publish the remainder in the same edge as the final step.
                    crc_d   = step_rem;
                    state_d = DONE;
                end
            end

            DONE: begin
                // Wait for E to drop so a held request cannot re-trigger.
                if (!E) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            msg_q   <= '0;
            poly_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            crc_q   <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            poly_q  <= poly_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
        end
    end

    assign CRC = crc_q;

endmodule : asm

// File: tb/tb_asm.sv
// Self-checking bench for the serial CRC generator.
// Expected remainders come from a polynomial long-division model and are
// queued at start time, then popped when the result edge arrives.
module tb_asm;
    import asm_pkg::*;

    logic        clk;
    logic        Reset;
    logic        E;
    logic [13:0] Data;
    logic [3:0]  Divisor;
    logic [2:0]  CRC;

    int n_checks = 0;
    int n_pass   = 0;

    logic [2:0] exp_q[$];
    logic [2:0] cur_crc;

    asm dut (
        .clk     (clk),
        .Reset   (Reset),
        .E       (E),
        .Data    (Data),
        .Divisor (Divisor),
        .CRC     (CRC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Textbook long division of d * x^3 by {1, dv[2:0]}.
    function automatic logic [2:0] crc_model(input logic [13:0] d, input logic [3:0] dv);
        logic [16:0] v;
        logic [3:0]  g;
        v = {d, 3'b000};
        g = {1'b1, dv[2:0]};
        for (int i = 16; i >= 3; i--) begin
            if (v[i]) v[i -: 4] = v[i -: 4] ^ g;
        end
        return v[2:0];
    endfunction

    // Start at a negedge, hold E for e_cyc edges (counting the start edge),
    // optionally disturb Data/Divisor after the start, then run to n_total cycles.
    task automatic run_calc(input logic [13:0] d, input logic [3:0] dv, input int e_cyc,
                            input bit chg, input logic [13:0] d_alt, input int n_total);
        logic [2:0] exp;
        @(negedge clk);
        Data    = d;
        Divisor = dv;
        E       = 1'b1;
        exp_q.push_back(crc_model(d, dv));
        @(posedge clk);                 // start edge T0
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            E = (k < e_cyc);
            if (chg) begin
                Data    = d_alt;
                Divisor = dv ^ 4'b0110;
            end
            @(posedge clk);
            #1;
            if (k < 17) begin
                check("hold_during_shift", CRC, cur_crc);
            end else begin
                exp = exp_q.pop_front();
                check("crc_result", CRC, exp);
                cur_crc = exp;
            end
        end
        for (int k = 18; k <= n_total; k++) begin
            @(negedge clk);
            E = (k < e_cyc);
            @(posedge clk);
            #1;
            check("crc_stable", CRC, cur_crc);
        end
        @(negedge clk);
        E = 1'b0;
    endtask

    initial begin
        logic [2:0]  junk;
        logic [13:0] rd;
        logic [3:0]  rv;

        Reset   = 1'b0;
        E       = 1'b0;
        Data    = '0;
        Divisor = 4'b1011;
        cur_crc = 3'b000;

        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("reset_crc", CRC, 3'b000);
        end
        @(negedge clk);
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("idle_crc", CRC, 3'b000);
        end

        // Classic example, E held 4 cycles, then 50 stable cycles.
        run_calc(14'b11010011101100, 4'b1011, 4, 1'b0, '0, 67);
        // Second frame: old value must hold during SHIFT.
        run_calc(14'b11000110000110, 4'b1011, 4, 1'b0, '0, 20);
        // All-zero and single-one messages, single-cycle E.
        run_calc(14'b00000000000000, 4'b1011, 1, 1'b0, '0, 20);
        run_calc(14'b00000000000001, 4'b1011, 1, 1'b0, '0, 20);
        // Inputs disturbed after the start edge.
        run_calc(14'b10101010101010, 4'b1011, 1, 1'b1, 14'h3FFF, 20);
        // E held far past completion with different inputs: no restart.
        run_calc(14'b01110010110001, 4'b1101, 30, 1'b1, 14'b11010011101100, 60);
        // Divisor MSB ignored; degenerate low bits 000.
        run_calc(14'b11010011101100, 4'b0011, 1, 1'b0, '0, 20);
        run_calc(14'b10110111011101, 4'b1000, 1, 1'b0, '0, 20);

        // Reset during step 8 aborts and clears CRC.
        @(negedge clk);
        Data    = 14'b11000110000110;
        Divisor = 4'b1011;
        E       = 1'b1;
        exp_q.push_back(crc_model(Data, Divisor));
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            E = 1'b0;
            @(posedge clk);
            #1;
            check("hold_before_abort", CRC, cur_crc);
        end
        @(negedge clk);
        Reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_crc", CRC, 3'b000);
        check("abort_state", {1'b0, dut.state_q}, {1'b0, IDLE});
        junk    = exp_q.pop_front();
        cur_crc = 3'b000;
        @(negedge clk);
        Reset = 1'b1;
        run_calc(14'b11010011101100, 4'b1011, 2, 1'b0, '0, 20);

        // A few random frames.
        for (int n = 0; n < 4; n++) begin
            rd = 14'($urandom);
            rv = 4'($urandom);
            run_calc(rd, rv, 1 + int'($urandom_range(0, 3)), 1'b0, '0, 20);
        end

        check("queue_drained", 3'(exp_q.size()), 3'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_asm
